// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter
//  Description : Parametrised synchronous up/down counter with parallel load,
//                wrap-around or saturating limits, and a terminal-count pulse.
//                The count is held in binary and also presented as reflected
//                Gray code. Both outputs are registered from the same next
//                state, so they always agree with each other.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_counter #(
  parameter int WIDTH   = 4,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] c_max  = '1;
  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] binary_q, binary_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_wrap_allowed;

  // Wrap/saturate policy is fixed at elaboration time.
  generate
    if (WRAP_EN) begin : g_wrap
      assign w_wrap_allowed = 1'b1;
    end else begin : g_sat
      assign w_wrap_allowed = 1'b0;
    end
  endgenerate

  assign w_at_max  = (binary_q == c_max);
  assign w_at_zero = (binary_q == c_zero);

  // Next-state: load beats counting; at a limit either wrap (with pulse) or hold.
  // Gray is derived from the next binary value so both registers move together.
  always_comb begin
    binary_d = binary_q;
    wrap_d   = 1'b0;
    if (load) begin
      binary_d = load_bin;
    end else if (en) begin
      if (up_dn) begin
        if (!w_at_max) begin
          binary_d = binary_q + c_one;
        end else if (w_wrap_allowed) begin
          binary_d = c_zero;
          wrap_d   = 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          binary_d = binary_q - c_one;
        end else if (w_wrap_allowed) begin
          binary_d = c_max;
          wrap_d   = 1'b1;
        end
      end
    end
    gray_d = binary_d ^ (binary_d >> 1);
  end

  // State registers with synchronous reset taking precedence over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      binary_q <= c_zero;
      gray_q   <= c_zero;
      wrap_q   <= 1'b0;
    end else begin
      binary_q <= binary_d;
      gray_q   <= gray_d;
      wrap_q   <= wrap_d;
    end
  end

  assign binary   = binary_q;
  assign gray     = gray_q;
  assign wrap     = wrap_q;
  assign at_limit = up_dn ? w_at_max : w_at_zero;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_counter
//  Description : Self-checking bench for gray_counter. Three instances
//                (4-bit wrap, 4-bit saturate, 8-bit wrap) are tracked by an
//                integer-arithmetic reference model and compared every cycle;
//                directed sequences pin known literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 4-bit wrapping instance
  logic       a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
  logic [3:0] a_lb = '0;
  logic [3:0] a_bin, a_gray;
  logic       a_wrap, a_lim;
  // 4-bit saturating instance
  logic       s_en = 1'b0, s_up = 1'b1, s_load = 1'b0;
  logic [3:0] s_lb = '0;
  logic [3:0] s_bin, s_gray;
  logic       s_wrap, s_lim;
  // 8-bit wrapping instance
  logic       b_en = 1'b0, b_up = 1'b1, b_load = 1'b0;
  logic [7:0] b_lb = '0;
  logic [7:0] b_bin, b_gray;
  logic       b_wrap, b_lim;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .WRAP_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .en(a_en), .up_dn(a_up), .load(a_load), .load_bin(a_lb),
    .binary(a_bin), .gray(a_gray), .wrap(a_wrap), .at_limit(a_lim));

  gray_counter #(.WIDTH(4), .WRAP_EN(1'b0)) u_dut_s (
    .clk(clk), .rst(rst), .en(s_en), .up_dn(s_up), .load(s_load), .load_bin(s_lb),
    .binary(s_bin), .gray(s_gray), .wrap(s_wrap), .at_limit(s_lim));

  gray_counter #(.WIDTH(8), .WRAP_EN(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .en(b_en), .up_dn(b_up), .load(b_load), .load_bin(b_lb),
    .binary(b_bin), .gray(b_gray), .wrap(b_wrap), .at_limit(b_lim));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: step the count as an unbounded integer and resolve out-of-range
  // results by modulo (wrap mode) or by refusing the step (saturate mode).
  function automatic void model_step(input int w, input bit we, input bit r,
                                     input bit e, input bit u, input bit l,
                                     input int lb, inout int b, inout bit wr,
                                     output bit mv);
    int span;
    int nb;
    span = 1 << w;
    mv   = 1'b0;
    wr   = 1'b0;
    if (r) begin
      b = 0;
    end else if (l) begin
      b = lb;
    end else if (e) begin
      nb = u ? b + 1 : b - 1;
      if (nb < 0 || nb >= span) begin
        if (we) begin
          b  = (nb + span) % span;
          wr = 1'b1;
          mv = 1'b1;
        end
      end else begin
        b  = nb;
        mv = 1'b1;
      end
    end
  endfunction

  int ma_b = 0, ms_b = 0, mb_b = 0;
  bit ma_w = 0, ms_w = 0, mb_w = 0;
  bit ma_mv = 0, ms_mv = 0, mb_mv = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    model_step(4, 1'b1, rst, a_en, a_up, a_load, int'(a_lb), ma_b, ma_w, ma_mv);
    model_step(4, 1'b0, rst, s_en, s_up, s_load, int'(s_lb), ms_b, ms_w, ms_mv);
    model_step(8, 1'b1, rst, b_en, b_up, b_load, int'(b_lb), mb_b, mb_w, mb_mv);
    m_valid = 1'b1;
  end

  logic [3:0] pa_gray, ps_gray;
  logic [7:0] pb_gray;

  // Compare every instance against the model one time-step after each edge.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("a_binary", 32'(a_bin), 32'(ma_b));
      chk("a_gray",   32'(a_gray), 32'(ma_b ^ (ma_b >> 1)));
      chk("a_wrap",   32'(a_wrap), 32'(ma_w));
      chk("a_limit",  32'(a_lim), 32'(a_up ? (ma_b == 15) : (ma_b == 0)));
      if (ma_mv) chk("a_gray_1bit", 32'($countones(a_gray ^ pa_gray)), 32'd1);

      chk("s_binary", 32'(s_bin), 32'(ms_b));
      chk("s_gray",   32'(s_gray), 32'(ms_b ^ (ms_b >> 1)));
      chk("s_wrap",   32'(s_wrap), 32'(ms_w));
      chk("s_limit",  32'(s_lim), 32'(s_up ? (ms_b == 15) : (ms_b == 0)));
      if (ms_mv) chk("s_gray_1bit", 32'($countones(s_gray ^ ps_gray)), 32'd1);

      chk("b_binary", 32'(b_bin), 32'(mb_b));
      chk("b_gray",   32'(b_gray), 32'(mb_b ^ (mb_b >> 1)));
      chk("b_wrap",   32'(b_wrap), 32'(mb_w));
      chk("b_limit",  32'(b_lim), 32'(b_up ? (mb_b == 255) : (mb_b == 0)));
      if (mb_mv) chk("b_gray_1bit", 32'($countones(b_gray ^ pb_gray)), 32'd1);
    end
    pa_gray = a_gray;
    ps_gray = s_gray;
    pb_gray = b_gray;
  end

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq [0:16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                             4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                             4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  initial begin
    // Reset held while load and en are also active on every instance.
    a_en = 1'b1; a_load = 1'b1; a_lb = 4'd5;
    s_en = 1'b1; s_load = 1'b1; s_lb = 4'd9;
    b_en = 1'b1; b_load = 1'b1; b_lb = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      after_edge();
      chk("rst_binary", 32'(a_bin), 32'd0);
      chk("rst_gray",   32'(a_gray), 32'd0);
      chk("rst_wrap",   32'(a_wrap), 32'd0);
      chk("rst_b_bin",  32'(b_bin), 32'd0);
    end

    // Release reset and sweep the 4-bit wrapping counter upward.
    @(negedge clk);
    rst = 1'b0;
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
    s_load = 1'b0; s_en = 1'b0;
    b_load = 1'b0; b_en = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      after_edge();
      chk("sweep_gray", 32'(a_gray), 32'(seq[k]));
      chk("sweep_bin",  32'(a_bin), 32'(k % 16));
      chk("sweep_wrap", 32'(a_wrap), (k == 16) ? 32'd1 : 32'd0);
    end

    // Load 1 with en asserted, then count down through zero.
    @(negedge clk);
    a_load = 1'b1; a_lb = 4'd1; a_en = 1'b1; a_up = 1'b1;
    after_edge();
    chk("load1_bin",  32'(a_bin), 32'd1);
    chk("load1_gray", 32'(a_gray), 32'b0001);
    @(negedge clk);
    a_load = 1'b0; a_up = 1'b0;
    after_edge();
    chk("down0_bin",   32'(a_bin), 32'd0);
    chk("down0_gray",  32'(a_gray), 32'b0000);
    chk("down0_limit", 32'(a_lim), 32'd1);
    after_edge();
    chk("downwrap_bin",  32'(a_bin), 32'd15);
    chk("downwrap_gray", 32'(a_gray), 32'b1000);
    chk("downwrap_wrap", 32'(a_wrap), 32'd1);

    // Hold at 7, then a load must win over an active increment.
    @(negedge clk);
    a_load = 1'b1; a_lb = 4'd7;
    after_edge();
    @(negedge clk);
    a_load = 1'b0; a_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      after_edge();
      chk("hold_bin",  32'(a_bin), 32'd7);
      chk("hold_gray", 32'(a_gray), 32'b0100);
    end
    @(negedge clk);
    a_load = 1'b1; a_lb = 4'd9; a_en = 1'b1; a_up = 1'b1;
    after_edge();
    chk("prio_bin",  32'(a_bin), 32'd9);
    chk("prio_gray", 32'(a_gray), 32'b1101);

    // Reset coinciding with a wrap event clears everything.
    @(negedge clk);
    a_lb = 4'd15;
    after_edge();
    @(negedge clk);
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b1; rst = 1'b1;
    after_edge();
    chk("rstwrap_bin",  32'(a_bin), 32'd0);
    chk("rstwrap_wrap", 32'(a_wrap), 32'd0);
    @(negedge clk);
    rst = 1'b0; a_en = 1'b0;

    // Saturating instance pinned at max, then stepping back down.
    s_load = 1'b1; s_lb = 4'd14; s_en = 1'b1; s_up = 1'b1;
    after_edge();
    chk("sat_load", 32'(s_bin), 32'd14);
    @(negedge clk);
    s_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      after_edge();
      chk("sat_bin",   32'(s_bin), 32'd15);
      chk("sat_gray",  32'(s_gray), 32'b1000);
      chk("sat_wrap",  32'(s_wrap), 32'd0);
      chk("sat_limit", 32'(s_lim), 32'd1);
    end
    @(negedge clk);
    s_up = 1'b0;
    after_edge();
    chk("sat_down", 32'(s_bin), 32'd14);

    // Randomised traffic on all instances; the model compare covers it.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 199) == 0);
      a_en   = ($urandom_range(0, 3) != 0);
      a_up   = $urandom_range(0, 1) == 1;
      a_load = ($urandom_range(0, 15) == 0);
      a_lb   = 4'($urandom);
      s_en   = ($urandom_range(0, 3) != 0);
      s_up   = ($urandom_range(0, 7) < 5);
      s_load = ($urandom_range(0, 31) == 0);
      s_lb   = 4'($urandom);
      b_en   = ($urandom_range(0, 3) != 0);
      b_up   = $urandom_range(0, 1) == 1;
      b_load = ($urandom_range(0, 15) == 0);
      b_lb   = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00)
                                           : 8'($urandom);
    end

    @(negedge clk);
    rst = 1'b0; a_en = 1'b0; s_en = 1'b0; b_en = 1'b0;
    a_load = 1'b0; s_load = 1'b0; b_load = 1'b0;
    after_edge();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
